regs_mp: RTL and testbench
==========================

# regs_mp

Parametrised multi-port integer register file for the rua core, the successor to the two-read/two-write register block. It adds a configurable number of read and write ports with fixed-priority write arbitration and write-to-read forwarding. A per-register busy scoreboard supports hazard detection, and a sequential clear engine zeroes the array after reset or on a flush request. It sits between decode, which reads operands and marks destinations, and the execute and memory write-back stages.

## Interface
- XLEN, 32, data width of each register
- REG_COUNT, 32, number of registers; must be a power of two, at least 2
- ADDR_W, 5, register address width; equals log2(REG_COUNT)
- RD_PORTS, 2, number of read ports
- WR_PORTS, 2, number of write ports; port 0 has the highest priority
- ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never busy

- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous request to re-run the clear sequence
- rd_addr  in  RD_PORTS*ADDR_W  read addresses; port i is at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  RD_PORTS*XLEN  read data, combinational
- rd_busy  out  RD_PORTS  busy status of each read address, combinational
- wr_en  in  WR_PORTS  write enables
- wr_addr  in  WR_PORTS*ADDR_W  write addresses
- wr_data  in  WR_PORTS*XLEN  write data
- set_en  in  1  mark a register busy (destination issued)
- set_addr  in  ADDR_W  register to mark busy
- init_done  out  1  high when the clear sequence is complete and the file is usable

## Operation
- The block has two states.
  - INIT: a counter clr_idx walks from 0 to REG_COUNT-1 and writes one entry to zero per cycle.
  - RUN: normal operation.
- INIT to RUN: on the edge that clears entry REG_COUNT-1. clr_idx is then reset to 0.
- RUN to INIT: when flush=1 at a rising edge. Busy bits are cleared on that same edge.
- flush=1 while already in INIT restarts clr_idx at 0.
- During INIT:
  - wr_en and set_en are ignored.
  - rd_data is all 0 and rd_busy is all 0.
  - init_done is 0.
- Write arbitration in RUN: every enabled port whose address is not masked by ZERO_REG writes its entry. When several ports target the same address, the lowest-index port wins.
- Read forwarding: rd_data[i] is the data of the highest-priority enabled write port whose address matches rd_addr[i] this cycle; otherwise it is the stored entry.
- ZERO_REG=1: a read of address 0 returns 0 regardless of any write to address 0.
- Scoreboard: one busy bit per register.
  - set_en sets the bit for set_addr.
  - Any enabled write to an address clears its bit.
  - Same-cycle set and clear on the same address: set wins, because a new producer has issued.
  - ZERO_REG=1: set_en to address 0 is ignored.
- rd_busy[i] = busy[rd_addr[i]], forced to 0 when an enabled write to rd_addr[i] occurs this cycle. This is consistent with forwarding: the forwarded data is valid, so the register is not reported busy.
- Widths: addresses are used unmodified and never wrap, since REG_COUNT = 2^ADDR_W. Data is never extended or truncated.

## Timing
- Reset assertion, asynchronous:
  - state = INIT, clr_idx = 0, all busy bits = 0, init_done = 0.
  - rd_data = 0 and rd_busy = 0 immediately.
  - Array contents are don't-care until cleared.
- After rst_n deasserts, the first rising edge clears entry 0.
- init_done rises right after the REG_COUNT-th rising edge following deassertion: the 32nd edge at defaults.
- Reset asserted mid-INIT or mid-RUN aborts the current activity and restarts the sequence from clr_idx=0.
- Flush asserted at edge N: init_done is 0 from just after edge N and returns to 1 after edge N+REG_COUNT. Writes presented at edge N are discarded.
- Write latency: data is stored at the rising edge and visible at the same-cycle read through forwarding. It is visible from storage in the following cycle.
- set_en takes effect on the edge: rd_busy for that address is 1 in the next cycle.
- Read paths are purely combinational from rd_addr, wr_* and state; no read register stage.

## Test plan
- Reset release, then 32 idle cycles: init_done goes high exactly after edge 32; reads of regs 1..31 return 0x00000000 and rd_busy=0.
- wr_en=2'b11, both addresses=5, data 0xAAAA_0001 on port 0 and 0xBBBB_0002 on port 1: same-cycle rd_addr=5 returns 0xAAAA_0001; next cycle the stored value is 0xAAAA_0001.
- Write 0xDEADBEEF to reg 0 with ZERO_REG=1: rd_data for address 0 is 0 both in the same cycle and later; set_en to reg 0 leaves rd_busy=0.
- set_en to reg 7, then next cycle rd_addr=7: rd_busy=1. Cycle with wr_en[1] to reg 7 carrying 0x1234: rd_busy=0, rd_data=0x1234. Next cycle busy stays 0. Set and write to reg 7 in the same cycle: busy=1 afterwards.
- Fill regs 1..31 with nonzero values and mark reg 3 busy, then pulse flush: init_done=0 for 32 cycles, writes during that window are ignored, all regs read 0 and no register is busy afterwards.
- Assert rst_n=0 for one cycle midway through INIT at clr_idx=10: init_done goes high exactly 32 edges after the re-release.

Source files
------------

// File: rtl/regs_mp.sv
// Multi-port integer register file with fixed-priority writes, write-to-read
// forwarding, a per-register busy scoreboard and a sequential clear engine.
module regs_mp #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32,
  parameter int ADDR_W    = 5,
  parameter int RD_PORTS  = 2,
  parameter int WR_PORTS  = 2,
  parameter int ZERO_REG  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [RD_PORTS*XLEN-1:0]     rd_data,
  output logic [RD_PORTS-1:0]          rd_busy,
  input  logic [WR_PORTS-1:0]          wr_en,
  input  logic [WR_PORTS*ADDR_W-1:0]   wr_addr,
  input  logic [WR_PORTS*XLEN-1:0]     wr_data,
  input  logic                         set_en,
  input  logic [ADDR_W-1:0]            set_addr,
  output logic                         init_done
);

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_n_s;
  logic [ADDR_W-1:0]     clr_idx_r;
  logic [ADDR_W-1:0]     clr_idx_n_s;
  logic                  init_done_r;
  logic [XLEN-1:0]       regs_r [REG_COUNT];
  logic [REG_COUNT-1:0]  busy_r;
  logic [REG_COUNT-1:0]  busy_n_s;
  logic [ADDR_W-1:0]     ra_s;
  logic [XLEN-1:0]       val_s;
  logic                  bsy_s;
  logic                  hit_s;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG == 1) && (addr == {ADDR_W{1'b0}});
  endfunction

  // State, clear index and init_done registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= INIT;
      clr_idx_r   <= {ADDR_W{1'b0}};
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      clr_idx_r   <= clr_idx_n_s;
      init_done_r <= (state_n_s == RUN);
    end
  end

  // Next-state logic: walk the clear index in INIT, re-enter INIT on flush
  always_comb begin
    state_n_s   = state_r;
    clr_idx_n_s = clr_idx_r;
    case (state_r)
      INIT: begin
        if (flush) begin
          clr_idx_n_s = {ADDR_W{1'b0}};
        end else if (clr_idx_r == ADDR_W'(REG_COUNT - 1)) begin
          state_n_s   = RUN;
          clr_idx_n_s = {ADDR_W{1'b0}};
        end else begin
          clr_idx_n_s = clr_idx_r + ADDR_W'(1);
        end
      end
      RUN: begin
        if (flush) begin
          state_n_s   = INIT;
          clr_idx_n_s = {ADDR_W{1'b0}};
        end else begin
          state_n_s   = RUN;
        end
      end
      default: begin
        state_n_s   = INIT;
        clr_idx_n_s = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Storage array; the high-index ports are applied first so port 0 lands last
  always_ff @(posedge clk) begin
    if (state_r == INIT) begin
      regs_r[clr_idx_r] <= {XLEN{1'b0}};
    end else if (!flush) begin
      for (int j = WR_PORTS - 1; j >= 0; j--) begin
        if (wr_en[j] && !is_zero_reg(wr_addr[j*ADDR_W +: ADDR_W])) begin
          regs_r[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Scoreboard update: writes retire producers, a same-cycle issue wins
  always_comb begin
    busy_n_s = busy_r;
    if ((state_r != RUN) || flush) begin
      busy_n_s = {REG_COUNT{1'b0}};
    end else begin
      for (int j = 0; j < WR_PORTS; j++) begin
        busy_n_s[wr_addr[j*ADDR_W +: ADDR_W]] =
          busy_n_s[wr_addr[j*ADDR_W +: ADDR_W]] & ~wr_en[j];
      end
      busy_n_s[set_addr] = busy_n_s[set_addr] | (set_en & ~is_zero_reg(set_addr));
    end
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= {REG_COUNT{1'b0}};
    end else begin
      busy_r <= busy_n_s;
    end
  end

  // Combinational read ports with forwarding from the winning write port
  always_comb begin
    rd_data = {(RD_PORTS*XLEN){1'b0}};
    rd_busy = {RD_PORTS{1'b0}};
    ra_s    = {ADDR_W{1'b0}};
    val_s   = {XLEN{1'b0}};
    bsy_s   = 1'b0;
    hit_s   = 1'b0;
    for (int i = 0; i < RD_PORTS; i++) begin
      ra_s  = rd_addr[i*ADDR_W +: ADDR_W];
      val_s = regs_r[ra_s];
      bsy_s = busy_r[ra_s];
      for (int j = WR_PORTS - 1; j >= 0; j--) begin
        hit_s = wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ra_s);
        val_s = hit_s ? wr_data[j*XLEN +: XLEN] : val_s;
        bsy_s = bsy_s & ~hit_s;
      end
      if ((state_r != RUN) || is_zero_reg(ra_s)) begin
        val_s = {XLEN{1'b0}};
        bsy_s = 1'b0;
      end else begin
        bsy_s = bsy_s;
      end
      rd_data[i*XLEN +: XLEN] = val_s;
      rd_busy[i]              = bsy_s;
    end
  end

  assign init_done = init_done_r;

endmodule

// File: tb/tb_regs_mp.sv
// Randomized self-checking bench for regs_mp against a behavioural model.
module tb_regs_mp;
  localparam int XLEN = 32;
  localparam int RC   = 32;
  localparam int AW   = 5;
  localparam int RP   = 2;
  localparam int WP   = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [RP*AW-1:0]   rd_addr = '0;
  logic [RP*XLEN-1:0] rd_data;
  logic [RP-1:0]      rd_busy;
  logic [WP-1:0]      wr_en = '0;
  logic [WP*AW-1:0]   wr_addr = '0;
  logic [WP*XLEN-1:0] wr_data = '0;
  logic             set_en = 1'b0;
  logic [AW-1:0]    set_addr = '0;
  logic             init_done;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] mem [RC];
  bit              bsy [RC];
  int              init_left;

  regs_mp #(.XLEN(XLEN), .REG_COUNT(RC), .ADDR_W(AW), .RD_PORTS(RP),
            .WR_PORTS(WP), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .set_en(set_en), .set_addr(set_addr), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < RC; k++) begin
      mem[k] = '0;
      bsy[k] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic [AW-1:0]   a;
    logic [XLEN-1:0] ed;
    bit              eb;
    chk("init_done", 64'(init_done), 64'(init_left == 0));
    for (int i = 0; i < RP; i++) begin
      a  = rd_addr[i*AW +: AW];
      ed = '0;
      eb = 1'b0;
      if (init_left == 0 && a != 0) begin
        ed = mem[a];
        eb = bsy[a];
        for (int j = 0; j < WP; j++) begin
          if (wr_en[j] && wr_addr[j*AW +: AW] == a) begin
            ed = wr_data[j*XLEN +: XLEN];
            eb = 1'b0;
            break;
          end
        end
      end
      chk($sformatf("rd_data%0d@%0d", i, a), 64'(rd_data[i*XLEN +: XLEN]), 64'(ed));
      chk($sformatf("rd_busy%0d@%0d", i, a), 64'(rd_busy[i]), 64'(eb));
    end
  endtask

  task automatic model_edge();
    logic [AW-1:0] a;
    if (init_left > 0) begin
      init_left = flush ? RC : init_left - 1;
    end else if (flush) begin
      init_left = RC;
      model_clear();
    end else begin
      for (int j = WP - 1; j >= 0; j--) begin
        a = wr_addr[j*AW +: AW];
        if (wr_en[j]) begin
          if (a != 0) mem[a] = wr_data[j*XLEN +: XLEN];
          bsy[a] = 1'b0;
        end
      end
      if (set_en && set_addr != 0) bsy[set_addr] = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    wr_en  = '0;
    set_en = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    init_left = RC;
    model_clear();
    #1;
    check_outputs();
    chk("rst_data", 64'(rd_data), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic wait_done(input string tag);
    int e;
    e = 0;
    while (!init_done && e < 64) begin
      step();
      e++;
    end
    chk(tag, 64'(e), 64'(RC));
  endtask

  initial begin
    idle_inputs();
    #2;
    do_reset();
    wait_done("done_edge_reset");

    // every register reads zero after the clear
    for (int a = 0; a < RC; a += 2) begin
      set_rd(AW'(a), AW'(a + 1));
      step();
    end

    // port 0 wins on a same-address collision
    wr_en = 2'b11; wr_addr = {5'd5, 5'd5};
    wr_data = {32'hBBBB_0002, 32'hAAAA_0001};
    set_rd(5'd5, 5'd5);
    #1 chk("fwd_prio", 64'(rd_data[31:0]), 64'h0000_0000_AAAA_0001);
    step();
    idle_inputs();
    #1 chk("stored_prio", 64'(rd_data[63:32]), 64'h0000_0000_AAAA_0001);
    step();

    // register 0 is hard-wired
    wr_en = 2'b01; wr_addr = {5'd1, 5'd0}; wr_data = {32'h0, 32'hDEAD_BEEF};
    set_en = 1'b1; set_addr = 5'd0;
    set_rd(5'd0, 5'd0);
    step();
    idle_inputs();
    #1 chk("zero_reg", 64'({rd_busy[0], rd_data[31:0]}), 64'(0));
    step();

    // scoreboard set, forward-clear, set-wins
    set_en = 1'b1; set_addr = 5'd7; set_rd(5'd7, 5'd3);
    step();
    idle_inputs();
    #1 chk("busy_set", 64'(rd_busy[0]), 64'(1));
    step();
    wr_en = 2'b10; wr_addr = {5'd7, 5'd0}; wr_data = {32'h0000_1234, 32'h0};
    #1 chk("busy_fwd", 64'({rd_busy[0], rd_data[31:0]}), 64'h0000_1234);
    step();
    idle_inputs();
    step();
    set_en = 1'b1; set_addr = 5'd7; wr_en = 2'b01; wr_addr = {5'd0, 5'd7};
    wr_data = {32'h0, 32'h0000_5678};
    step();
    idle_inputs();
    #1 chk("set_wins", 64'(rd_busy[0]), 64'(1));
    step();

    // fill, flush, writes ignored during the clear window
    for (int a = 1; a < RC; a += 2) begin
      wr_en = 2'b11;
      wr_addr = {AW'(a + 1), AW'(a)};
      wr_data = {32'hC000_0000 + 32'(a + 1), 32'hC000_0000 + 32'(a)};
      set_rd(AW'(a), AW'(a - 1));
      step();
    end
    idle_inputs();
    set_en = 1'b1; set_addr = 5'd3;
    step();
    idle_inputs();
    flush = 1'b1; wr_en = 2'b11; wr_data = {32'h1111_1111, 32'h2222_2222};
    step();
    flush = 1'b0;
    for (int c = 0; c < 40 && !init_done; c++) begin
      wr_en = 2'($urandom); wr_addr = WP*AW'($urandom); set_en = 1'b1;
      set_addr = AW'($urandom); set_rd(AW'($urandom), AW'($urandom));
      step();
    end
    chk("flush_done", 64'(init_done), 64'(1));
    idle_inputs();
    for (int a = 0; a < RC; a += 2) begin
      set_rd(AW'(a), AW'(a + 1));
      step();
    end

    // reset mid-clear at index 10
    do_reset();
    for (int c = 0; c < 10; c++) step();
    do_reset();
    wait_done("done_edge_rerelease");

    // randomized traffic with occasional flush and reset
    for (int c = 0; c < 3000; c++) begin
      wr_en = 2'($urandom);
      for (int j = 0; j < WP; j++) begin
        wr_addr[j*AW +: AW] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
        wr_data[j*XLEN +: XLEN] = $urandom;
      end
      set_en   = 1'($urandom);
      set_addr = AW'($urandom_range(0, 7));
      set_rd(AW'($urandom_range(0, 9)), AW'($urandom));
      flush    = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 399) == 0) do_reset();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
